// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch/jump resolution with registered PC redirect,
//               fixed-length pipeline flush and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int N            = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_is_branch,
    input  logic          ex_is_jal,
    input  logic          ex_is_jalr,
    input  logic [2:0]    ex_funct3,
    input  logic [N-1:0]  ex_pc,
    input  logic [N-1:0]  ex_imm,
    input  logic [N-1:0]  ex_rs1_data,
    input  logic          stall,
    input  logic          BrEq,
    input  logic          BrLt,
    output logic          BrUn,
    output logic          redirect_valid,
    output logic [N-1:0]  redirect_pc,
    output logic          flush,
    output logic          misalign_exc,
    output logic [CW-1:0] branch_count,
    output logic [CW-1:0] mispredict_count
);

    localparam logic [1:0]    c_ST_IDLE    = 2'd0;
    localparam logic [1:0]    c_ST_REDIR   = 2'd1;
    localparam logic [1:0]    c_ST_FLUSH   = 2'd2;
    localparam logic [2:0]    c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [N-1:0]  c_CLR_LSB    = {{(N-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] c_CNT_MAX    = {CW{1'b1}};

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [2:0]    r_flush_cnt;
    logic          r_redirect_valid;
    logic [N-1:0]  r_redirect_pc;
    logic          r_misalign;
    logic [CW-1:0] r_branch_cnt;
    logic [CW-1:0] r_mispredict_cnt;

    logic          w_accept;
    logic          w_is_jump;
    logic          w_is_cond;
    logic          w_cond_taken;
    logic          w_taken;
    logic [N-1:0]  w_sum_pc;
    logic [N-1:0]  w_sum_rs1;
    logic [N-1:0]  w_target;
    logic          w_redirect_go;
    logic          w_misalign_go;
    logic          w_flush;

    assign BrUn = ex_funct3[1];

    always_comb begin
        w_cond_taken = 1'b0;
        case (ex_funct3)
            3'b000:          w_cond_taken = BrEq;
            3'b001:          w_cond_taken = ~BrEq;
            3'b100, 3'b110:  w_cond_taken = BrLt;
            3'b101, 3'b111:  w_cond_taken = ~BrLt;
            default:         w_cond_taken = 1'b0;
        endcase
    end

    // jalr > jal > branch: a conditional branch only counts as one when no jump flag is set
    assign w_accept      = (r_state == c_ST_IDLE) & ex_valid & ~stall;
    assign w_is_jump     = ex_is_jal | ex_is_jalr;
    assign w_is_cond     = ex_is_branch & ~w_is_jump;
    assign w_taken       = w_is_jump | (w_is_cond & w_cond_taken);
    assign w_sum_pc      = ex_pc + ex_imm;
    assign w_sum_rs1     = ex_rs1_data + ex_imm;
    assign w_target      = ex_is_jalr ? (w_sum_rs1 & c_CLR_LSB) : w_sum_pc;
    assign w_redirect_go = w_accept & w_taken & ~w_target[1];
    assign w_misalign_go = w_accept & w_taken &  w_target[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_redirect_go) w_state_next = c_ST_REDIR;
            end
            c_ST_REDIR: begin
                w_state_next = (FLUSH_CYCLES > 1) ? c_ST_FLUSH : c_ST_IDLE;
            end
            c_ST_FLUSH: begin
                if (!stall && r_flush_cnt <= 3'd1) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_flush = 1'b0;
        case (r_state)
            c_ST_REDIR, c_ST_FLUSH: w_flush = 1'b1;
            default:                w_flush = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_cnt <= 3'd0;
        end else if (r_state == c_ST_REDIR) begin
            r_flush_cnt <= c_FLUSH_LOAD;
        end else if (r_state == c_ST_FLUSH && !stall && r_flush_cnt != 3'd0) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_misalign       <= 1'b0;
        end else begin
            r_redirect_valid <= w_redirect_go;
            r_misalign       <= w_misalign_go;
            if (w_redirect_go) r_redirect_pc <= w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_accept && w_is_cond && r_branch_cnt != c_CNT_MAX)
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_accept && w_taken && r_mispredict_cnt != c_CNT_MAX)
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
        end
    end

    assign flush            = w_flush;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign misalign_exc     = r_misalign;
    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data;
    logic        stall, BrEq, BrLt;

    logic        brun_a, rv_a, fl_a, mis_a;
    logic [31:0] rpc_a;
    logic [15:0] bc_a, mc_a;
    logic        brun_b, rv_b, fl_b, mis_b;
    logic [31:0] rpc_b;
    logic [15:0] bc_b, mc_b;
    logic        brun_c, rv_c, fl_c, mis_c;
    logic [31:0] rpc_c;
    logic [3:0]  bc_c, mc_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.N(32), .FLUSH_CYCLES(2), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .stall(stall),
        .BrEq(BrEq), .BrLt(BrLt), .BrUn(brun_a), .redirect_valid(rv_a),
        .redirect_pc(rpc_a), .flush(fl_a), .misalign_exc(mis_a),
        .branch_count(bc_a), .mispredict_count(mc_a));

    branch_resolve_unit #(.N(32), .FLUSH_CYCLES(3), .CW(16)) u_dut_f3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .stall(stall),
        .BrEq(BrEq), .BrLt(BrLt), .BrUn(brun_b), .redirect_valid(rv_b),
        .redirect_pc(rpc_b), .flush(fl_b), .misalign_exc(mis_b),
        .branch_count(bc_b), .mispredict_count(mc_b));

    branch_resolve_unit #(.N(32), .FLUSH_CYCLES(2), .CW(4)) u_dut_cw4 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .stall(stall),
        .BrEq(BrEq), .BrLt(BrLt), .BrUn(brun_c), .redirect_valid(rv_c),
        .redirect_pc(rpc_c), .flush(fl_c), .misalign_exc(mis_c),
        .branch_count(bc_c), .mispredict_count(mc_c));

    // Inputs change and outputs are sampled 1ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic eq, input logic lt);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1_data = rs1;
        BrEq = eq; BrLt = lt;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        do_reset();
        n_tests++; if (rv_a !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0b want 0", rv_a); end
        n_tests++; if (rpc_a !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got %h want 0", rpc_a); end
        n_tests++; if (fl_a !== 1'b0 || mis_a !== 1'b0) begin n_fail++; $display("FAIL reset_flush_mis got %0b/%0b want 0/0", fl_a, mis_a); end
        n_tests++; if (bc_a !== 16'd0 || mc_a !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", bc_a, mc_a); end
    endtask

    task automatic test_blt_signed_unsigned();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1);
        #1;
        n_tests++; if (brun_a !== 1'b0) begin n_fail++; $display("FAIL blt_brun got %0b want 0", brun_a); end
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h120) begin n_fail++; $display("FAIL blt_redirect got %0b/%h want 1/00000120", rv_a, rpc_a); end
        n_tests++; if (fl_a !== 1'b1) begin n_fail++; $display("FAIL blt_flush1 got %0b want 1", fl_a); end
        n_tests++; if (bc_a !== 16'd1 || mc_a !== 16'd1) begin n_fail++; $display("FAIL blt_counts got %0d/%0d want 1/1", bc_a, mc_a); end
        tick();
        n_tests++; if (fl_a !== 1'b1 || rv_a !== 1'b0) begin n_fail++; $display("FAIL blt_flush2 got fl=%0b rv=%0b want 1/0", fl_a, rv_a); end
        tick();
        n_tests++; if (fl_a !== 1'b0) begin n_fail++; $display("FAIL blt_flush_end got %0b want 0", fl_a); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h200, 32'h40, 32'h0, 1'b0, 1'b1);
        #1;
        n_tests++; if (brun_a !== 1'b1) begin n_fail++; $display("FAIL bltu_brun got %0b want 1", brun_a); end
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h240) begin n_fail++; $display("FAIL bltu_redirect got %0b/%h want 1/00000240", rv_a, rpc_a); end
        n_tests++; if (bc_a !== 16'd2 || mc_a !== 16'd2) begin n_fail++; $display("FAIL bltu_counts got %0d/%0d want 2/2", bc_a, mc_a); end
        tick(); tick();
    endtask

    task automatic test_not_taken();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h300, 32'h8, 32'h0, 1'b1, 1'b0);
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b0 || fl_a !== 1'b0) begin n_fail++; $display("FAIL bne_nt got rv=%0b fl=%0b want 0/0", rv_a, fl_a); end
        n_tests++; if (bc_a !== 16'd3 || mc_a !== 16'd2) begin n_fail++; $display("FAIL bne_counts got %0d/%0d want 3/2", bc_a, mc_a); end
        // illegal funct3 counted as a branch but never taken
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h300, 32'h8, 32'h0, 1'b1, 1'b1);
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b0 || bc_a !== 16'd4 || mc_a !== 16'd2) begin n_fail++; $display("FAIL illegal_f3 got rv=%0b %0d/%0d want 0 4/2", rv_a, bc_a, mc_a); end
        // BGE taken when not less-than
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h400, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h3F0) begin n_fail++; $display("FAIL bge_taken got %0b/%h want 1/000003f0", rv_a, rpc_a); end
        n_tests++; if (bc_a !== 16'd5 || mc_a !== 16'd3) begin n_fail++; $display("FAIL bge_counts got %0d/%0d want 5/3", bc_a, mc_a); end
        tick(); tick();
    endtask

    task automatic test_jalr_align();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h1003, 1'b0, 1'b0);
        tick();
        idle_in();
        n_tests++; if (mis_a !== 1'b1 || rv_a !== 1'b0 || fl_a !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign got mis=%0b rv=%0b fl=%0b want 1/0/0", mis_a, rv_a, fl_a); end
        n_tests++; if (rpc_a !== 32'h3F0 || mc_a !== 16'd4) begin n_fail++; $display("FAIL jalr_mis_hold got %h/%0d want 000003f0/4", rpc_a, mc_a); end
        tick();
        n_tests++; if (mis_a !== 1'b0) begin n_fail++; $display("FAIL jalr_mis_pulse got %0b want 0", mis_a); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h3, 32'h1001, 1'b0, 1'b0);
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h1004 || mis_a !== 1'b0) begin n_fail++; $display("FAIL jalr_aligned got %0b/%h mis=%0b want 1/00001004/0", rv_a, rpc_a, mis_a); end
        tick(); tick();
    endtask

    task automatic test_priority();
        // all three flags with illegal funct3: must resolve as JALR, not counted as branch
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 32'h100, 32'h8, 32'h500, 1'b0, 1'b0);
        tick();
        idle_in();
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h508) begin n_fail++; $display("FAIL priority_jalr got %0b/%h want 1/00000508", rv_a, rpc_a); end
        n_tests++; if (bc_a !== 16'd5 || mc_a !== 16'd6) begin n_fail++; $display("FAIL priority_counts got %0d/%0d want 5/6", bc_a, mc_a); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int redirects;
        redirects = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h300, 32'h10, 32'h0, 1'b1, 1'b0);
        n_tests++; if (rv_a !== 1'b1 || rpc_a !== 32'h240) begin n_fail++; $display("FAIL wp_jal got %0b/%h want 1/00000240", rv_a, rpc_a); end
        tick();
        if (rv_a === 1'b1) redirects++;
        tick();
        if (rv_a === 1'b1) redirects++;
        idle_in();
        tick();
        if (rv_a === 1'b1) redirects++;
        n_tests++; if (redirects !== 0) begin n_fail++; $display("FAIL wp_extra_redirects got %0d want 0", redirects); end
        n_tests++; if (bc_a !== 16'd5 || mc_a !== 16'd7 || fl_a !== 1'b0) begin n_fail++; $display("FAIL wp_counts got %0d/%0d fl=%0b want 5/7/0", bc_a, mc_a, fl_a); end
    endtask

    task automatic test_stall_flush();
        int flush_cycles;
        do_reset();
        flush_cycles = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0);
        tick();
        idle_in();
        if (fl_b === 1'b1) flush_cycles++;
        n_tests++; if (rv_b !== 1'b1 || rpc_b !== 32'h10) begin n_fail++; $display("FAIL f3_redirect got %0b/%h want 1/00000010", rv_b, rpc_b); end
        tick();
        if (fl_b === 1'b1) flush_cycles++;
        n_tests++; if (rv_b !== 1'b0) begin n_fail++; $display("FAIL f3_redir_len got rv=%0b want 0", rv_b); end
        stall = 1'b1;
        tick(); if (fl_b === 1'b1) flush_cycles++;
        tick(); if (fl_b === 1'b1) flush_cycles++;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fl_b === 1'b1) flush_cycles++;
        end
        n_tests++; if (flush_cycles !== 5) begin n_fail++; $display("FAIL f3_stall_flush_len got %0d want 5", flush_cycles); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h80, 32'h80, 32'h0, 1'b0, 1'b0);
        tick();
        idle_in();
        tick();
        n_tests++; if (fl_a !== 1'b1) begin n_fail++; $display("FAIL rstflush_pre got %0b want 1", fl_a); end
        rst = 1'b0;
        tick();
        n_tests++; if (fl_a !== 1'b0 || rv_a !== 1'b0 || rpc_a !== 32'h0 || mis_a !== 1'b0) begin n_fail++; $display("FAIL rstflush_outs got fl=%0b rv=%0b rpc=%h mis=%0b want 0", fl_a, rv_a, rpc_a, mis_a); end
        n_tests++; if (bc_a !== 16'd0 || mc_a !== 16'd0) begin n_fail++; $display("FAIL rstflush_counts got %0d/%0d want 0/0", bc_a, mc_a); end
        rst = 1'b1;
        tick();
        n_tests++; if (fl_a !== 1'b0) begin n_fail++; $display("FAIL rstflush_after got %0b want 0", fl_a); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1000, 32'h100, 32'h0, 1'b1, 1'b0);
            tick();
            idle_in();
            tick(); tick();
            if (i == 14) begin
                n_tests++; if (mc_c !== 4'd15 || bc_c !== 4'd15) begin n_fail++; $display("FAIL sat_at15 got %0d/%0d want 15/15", mc_c, bc_c); end
            end
        end
        n_tests++; if (mc_c !== 4'd15 || bc_c !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d/%0d want 15/15", mc_c, bc_c); end
        n_tests++; if (mc_a !== 16'd20 || bc_a !== 16'd20) begin n_fail++; $display("FAIL sat_wide got %0d/%0d want 20/20", mc_a, bc_a); end
    endtask

    initial begin
        test_reset();
        test_blt_signed_unsigned();
        test_not_taken();
        test_jalr_align();
        test_priority();
        test_back_to_back();
        test_stall_flush();
        test_reset_mid_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the branch comparator interface.
- Drives BrUn into the comparator. Takes BrEq/BrLt back and decodes them against funct3 into a taken/not-taken decision.
- Under static predict-not-taken, a taken branch or jump produces a registered PC redirect and then a fixed-length pipeline flush.
- Sits in EX and feeds the fetch-stage PC mux and the IF/ID/EX squash controls. Also keeps saturating branch and mispredict counters for the CSR/debug path.

Parameters:
- N, 32, datapath and PC width
- FLUSH_CYCLES, 2, number of cycles flush stays high, counted from and including the redirect cycle; legal range 1..7
- CW, 16, width of each performance counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge)
- ex_valid  input  1  EX holds a real instruction this cycle
- ex_is_branch  input  1  conditional branch (B-type)
- ex_is_jal  input  1  JAL
- ex_is_jalr  input  1  JALR
- ex_funct3  input  3  branch funct3
- ex_pc  input  N  PC of the EX instruction
- ex_imm  input  N  sign-extended immediate
- ex_rs1_data  input  N  forwarded rs1, used as the JALR base
- stall  input  1  pipeline freeze
- BrEq  input  1  comparator equal result
- BrLt  input  1  comparator less-than result
- BrUn  output  1  comparator unsigned-compare select
- redirect_valid  output  1  fetch must load redirect_pc
- redirect_pc  output  N  corrected PC
- flush  output  1  squash IF/ID/EX contents
- misalign_exc  output  1  one-cycle pulse: taken target is not 4-byte aligned
- branch_count  output  CW  resolved conditional branches
- mispredict_count  output  CW  taken branches plus all jumps

Behaviour:
- BrUn is combinational: BrUn = ex_funct3[1]. It is 1 for BLTU/BGEU and independent of state.
- Condition decode, by funct3:
  - 000 BEQ: taken = BrEq
  - 001 BNE: taken = ~BrEq
  - 100/110 BLT/BLTU: taken = BrLt
  - 101/111 BGE/BGEU: taken = ~BrLt
  - 010/011: illegal, treated as not taken
- Jumps are always taken.
- Target computation, modulo 2^N with carry discarded:
  - Branch and JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1_data + ex_imm) with bit 0 cleared.
- An instruction is "accepted" when the FSM is in IDLE, ex_valid=1 and stall=0. Only accepted instructions are evaluated or counted.
- Priority when more than one of branch/jal/jalr is set: jalr > jal > branch.
- FSM states: IDLE, REDIR, FLUSH.
  - IDLE:
    - Accepted and taken, target[1]=0: register target into redirect_pc; go to REDIR.
    - Accepted and taken, target[1]=1: pulse misalign_exc next cycle; no redirect; stay in IDLE.
    - Otherwise: stay in IDLE.
  - REDIR (exactly 1 cycle, stall ignored):
    - redirect_valid=1 and flush=1.
    - Load the flush counter with FLUSH_CYCLES-1.
    - Go to FLUSH if FLUSH_CYCLES>1, else to IDLE.
  - FLUSH:
    - flush=1.
    - stall=1 holds the counter.
    - Otherwise decrement; on the transition to 0, go to IDLE.
  - In REDIR and FLUSH, ex_valid is wrong-path and is ignored: no decision, no counting.
- Output timing: redirect_valid, redirect_pc and misalign_exc are registered, so they appear one cycle after acceptance. flush is decoded from state.
- Counters, updated in the accept cycle:
  - branch_count += 1 for every accepted conditional branch, including illegal funct3 encodings.
  - mispredict_count += 1 for every accepted taken branch or jump, misaligned ones included.
  - Both saturate at 2^CW-1; no wrap.
- Reset values (rst=0 at a clock edge): state IDLE, redirect_valid=0, redirect_pc=0, flush=0, misalign_exc=0, both counters 0.
- Reset mid-REDIR or mid-FLUSH aborts immediately: flush drops the cycle after the reset edge.
- redirect_pc holds its last value while redirect_valid=0.

Test Plan:
- BLT signed vs unsigned: funct3=100, BrLt=1, ex_pc=0x100, ex_imm=0x20 → BrUn=0; next cycle redirect_valid=1 with redirect_pc=0x120; flush high for 2 cycles; mispredict_count=1, branch_count=1. Repeat with funct3=110 → BrUn=1.
- Not-taken BNE: funct3=001, BrEq=1 → no redirect, flush=0, branch_count increments, mispredict_count unchanged.
- JALR alignment:
  - rs1=0x1003, imm=0 → redirect_pc=0x1002? No: bit1 set, so misalign_exc pulses and there is no redirect.
  - rs1=0x1001, imm=0x3 → target 0x1004 → redirect to 0x1004.
- Wrong-path squash: taken JAL, then ex_valid=1 taken branches held during REDIR/FLUSH → exactly one redirect; counters change by 1 only.
- Stall in FLUSH with FLUSH_CYCLES=3: stall=1 for 2 cycles during FLUSH → flush stays high 5 cycles total; REDIR is not extended.
- Reset/saturation:
  - rst=0 during FLUSH → all outputs 0 next cycle.
  - With CW=4, issue 20 taken branches → mispredict_count holds at 15.
